// File: rtl/ram_16.sv
// Single-port synchronous RAM, Width x Depth, with a registered read port.
// Read-first on a same-edge read/write; asynchronous active-low reset clears the array and RdData.
module ram_16 #(
  parameter int Width  = 16,
  parameter int Depth  = 8,
  parameter int ADD_WD = 3
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic [Width-1:0]  WrData,
  input  logic [ADD_WD-1:0] Address,
  input  logic              WrEn,
  input  logic              RdEn,
  output logic [Width-1:0]  RdData
);

  logic [Width-1:0] mem_q [Depth];
  logic [Width-1:0] mem_d [Depth];
  logic [Width-1:0] rd_data_q;
  logic [Width-1:0] rd_data_d;

  // The read samples mem_q, so a same-edge write is not visible until the next read.
  always_comb begin
    mem_d     = mem_q;
    rd_data_d = rd_data_q;
    if (WrEn) begin
      mem_d[Address] = WrData;
    end
    if (RdEn) begin
      rd_data_d = mem_q[Address];
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      for (int i = 0; i < Depth; i++) begin
        mem_q[i] <= '0;
      end
      rd_data_q <= '0;
    end else begin
      mem_q     <= mem_d;
      rd_data_q <= rd_data_d;
    end
  end

  assign RdData = rd_data_q;

endmodule

// File: tb/tb_ram_16.sv
// Self-checking bench for ram_16: directed scenarios plus randomized traffic
// compared against an array-based reference memory.
module tb_ram_16;

  localparam int W = 16;
  localparam int D = 8;
  localparam int A = 3;

  logic         CLK;
  logic         RST;
  logic [W-1:0] WrData;
  logic [A-1:0] Address;
  logic         WrEn;
  logic         RdEn;
  logic [W-1:0] RdData;

  int tests_run = 0;
  int tests_failed = 0;

  logic [W-1:0] ref_mem [D];
  logic [W-1:0] ref_rd;

  ram_16 #(.Width(W), .Depth(D), .ADD_WD(A)) dut (
    .CLK    (CLK),
    .RST    (RST),
    .WrData (WrData),
    .Address(Address),
    .WrEn   (WrEn),
    .RdEn   (RdEn),
    .RdData (RdData)
  );

  // Clock / reset block
  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  initial begin
    RST     = 1'b1;
    WrData  = '0;
    Address = '0;
    WrEn    = 1'b0;
    RdEn    = 1'b0;
  end

  task automatic ref_clear();
    for (int i = 0; i < D; i++) ref_mem[i] = '0;
    ref_rd = '0;
  endtask

  // Driver: present one access, clock it, update the reference, settle 1 time unit past the edge.
  task automatic drive(input logic [A-1:0] a, input logic [W-1:0] d,
                       input logic we, input logic re);
    logic [W-1:0] old_word;
    Address = a;
    WrData  = d;
    WrEn    = we;
    RdEn    = re;
    @(posedge CLK);
    old_word = ref_mem[a];
    if (RST) begin
      if (re) ref_rd = old_word;
      if (we) ref_mem[a] = d;
    end
    #1;
    WrEn = 1'b0;
    RdEn = 1'b0;
  endtask

  task automatic test_reset();
    #2;
    RST = 1'b0;
    ref_clear();
    #1;
    tests_run++;
    if (RdData !== 16'h0000) begin
      tests_failed++;
      $display("[TB] FAIL reset_initial: RdData=%h expected 0000", RdData);
    end
    // Enables held high during reset must have no effect.
    drive(3'd2, 16'hBEEF, 1'b1, 1'b1);
    tests_run++;
    if (RdData !== 16'h0000) begin
      tests_failed++;
      $display("[TB] FAIL reset_overrides_enables: RdData=%h expected 0000", RdData);
    end
    RST = 1'b1;
    drive(3'd2, 16'h0000, 1'b0, 1'b1);
    tests_run++;
    if (RdData !== 16'h0000) begin
      tests_failed++;
      $display("[TB] FAIL reset_write_ignored: RdData=%h expected 0000", RdData);
    end
  endtask

  task automatic test_write_read();
    drive(3'd4, 16'd35, 1'b1, 1'b0);
    drive(3'd4, 16'd0, 1'b0, 1'b1);
    tests_run++;
    if (RdData !== 16'd35) begin
      tests_failed++;
      $display("[TB] FAIL write_read_a4: RdData=%0d expected 35", RdData);
    end
    drive(3'd1, 16'd15, 1'b1, 1'b0);
    drive(3'd1, 16'd0, 1'b0, 1'b1);
    tests_run++;
    if (RdData !== 16'd15) begin
      tests_failed++;
      $display("[TB] FAIL write_read_a1: RdData=%0d expected 15", RdData);
    end
    drive(3'd4, 16'd0, 1'b0, 1'b1);
    tests_run++;
    if (RdData !== 16'd35) begin
      tests_failed++;
      $display("[TB] FAIL no_alias_a4: RdData=%0d expected 35", RdData);
    end
    drive(3'd1, 16'd0, 1'b0, 1'b1);
  endtask

  task automatic test_hold();
    for (int i = 0; i < 4; i++) begin
      drive(3'($urandom_range(0, D - 1)), 16'($urandom), 1'b0, 1'b0);
      tests_run++;
      if (RdData !== 16'd15) begin
        tests_failed++;
        $display("[TB] FAIL hold_idle_%0d: RdData=%0d expected 15", i, RdData);
      end
    end
    drive(3'd1, 16'd99, 1'b1, 1'b0);
    tests_run++;
    if (RdData !== 16'd15) begin
      tests_failed++;
      $display("[TB] FAIL hold_on_write: RdData=%0d expected 15", RdData);
    end
    drive(3'd1, 16'd0, 1'b0, 1'b1);
    tests_run++;
    if (RdData !== 16'd99) begin
      tests_failed++;
      $display("[TB] FAIL write_no_rden_stored: RdData=%0d expected 99", RdData);
    end
  endtask

  task automatic test_simultaneous();
    drive(3'd4, 16'd77, 1'b1, 1'b1);
    tests_run++;
    if (RdData !== 16'd35) begin
      tests_failed++;
      $display("[TB] FAIL read_first_old: RdData=%0d expected 35", RdData);
    end
    drive(3'd4, 16'd0, 1'b0, 1'b1);
    tests_run++;
    if (RdData !== 16'd77) begin
      tests_failed++;
      $display("[TB] FAIL read_first_new: RdData=%0d expected 77", RdData);
    end
  endtask

  task automatic test_sweep();
    logic [W-1:0] exp_word;
    for (int i = 0; i < D; i++) drive(3'(i), 16'(i * 16'h1111), 1'b1, 1'b0);
    for (int i = D - 1; i >= 0; i--) begin
      drive(3'(i), 16'h0000, 1'b0, 1'b1);
      exp_word = 16'(i * 16'h1111);
      tests_run++;
      if (RdData !== exp_word) begin
        tests_failed++;
        $display("[TB] FAIL sweep_a%0d: RdData=%h expected %h", i, RdData, exp_word);
      end
    end
  endtask

  task automatic test_async_reset_mid();
    drive(3'd6, 16'hA5A5, 1'b1, 1'b0);
    drive(3'd6, 16'h0000, 1'b0, 1'b1);
    tests_run++;
    if (RdData !== 16'hA5A5) begin
      tests_failed++;
      $display("[TB] FAIL pre_reset_read: RdData=%h expected a5a5", RdData);
    end
    // Assert reset between edges with a write pending; it must be lost.
    Address = 3'd3;
    WrData  = 16'h1234;
    WrEn    = 1'b1;
    #2;
    RST = 1'b0;
    ref_clear();
    #1;
    tests_run++;
    if (RdData !== 16'h0000) begin
      tests_failed++;
      $display("[TB] FAIL async_reset_immediate: RdData=%h expected 0000", RdData);
    end
    WrEn = 1'b0;
    @(posedge CLK);
    #1;
    RST = 1'b1;
    for (int i = 0; i < D; i++) begin
      drive(3'(i), 16'h0000, 1'b0, 1'b1);
      tests_run++;
      if (RdData !== 16'h0000) begin
        tests_failed++;
        $display("[TB] FAIL post_reset_a%0d: RdData=%h expected 0000", i, RdData);
      end
    end
  endtask

  task automatic test_random();
    logic [A-1:0] a;
    logic [W-1:0] d;
    logic         we;
    logic         re;
    for (int n = 0; n < 300; n++) begin
      a  = 3'($urandom_range(0, D - 1));
      d  = 16'($urandom);
      we = 1'($urandom_range(0, 1));
      re = 1'($urandom_range(0, 1));
      drive(a, d, we, re);
      tests_run++;
      if (RdData !== ref_rd) begin
        tests_failed++;
        $display("[TB] FAIL random_%0d a=%0d we=%0b re=%0b: RdData=%h expected %h",
                 n, a, we, re, RdData, ref_rd);
      end
    end
  endtask

  initial begin
    ref_clear();
    test_reset();
    test_write_read();
    test_hold();
    test_simultaneous();
    test_sweep();
    test_async_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL timeout: simulation did not complete, expected finish");
    $fatal(1);
  end

endmodule
